// File: rtl/page_walker_if.sv
// page_walker_if: requester, memory-port and result signals of the Sv32 page-table walker
interface page_walker_if #(
  parameter int NUM_RQ = 2,
  parameter int ID_W = 1
);
  logic [NUM_RQ-1:0]       IN_rqValid;
  logic [NUM_RQ-1:0][19:0] IN_rqVpn;
  logic [NUM_RQ-1:0]       OUT_rqReady;
  logic [21:0]             IN_satpPpn;
  logic                    OUT_memValid;
  logic [33:0]             OUT_memAddr;
  logic                    IN_memReady;
  logic                    IN_memRespValid;
  logic [31:0]             IN_memRespData;
  logic                    OUT_resValid;
  logic [ID_W-1:0]         OUT_resRqID;
  logic [19:0]             OUT_resVpn;
  logic [21:0]             OUT_resPpn;
  logic                    OUT_resIsSuper;
  logic [2:0]              OUT_resRwx;
  logic                    OUT_resUser;
  logic                    OUT_resGlobl;
  logic                    OUT_resPageFault;
  logic                    OUT_busy;
  modport slave (
    input  IN_rqValid, IN_rqVpn, IN_satpPpn, IN_memReady, IN_memRespValid, IN_memRespData,
    output OUT_rqReady, OUT_memValid, OUT_memAddr, OUT_resValid, OUT_resRqID, OUT_resVpn,
           OUT_resPpn, OUT_resIsSuper, OUT_resRwx, OUT_resUser, OUT_resGlobl,
           OUT_resPageFault, OUT_busy
  );
  modport master (
    output IN_rqValid, IN_rqVpn, IN_satpPpn, IN_memReady, IN_memRespValid, IN_memRespData,
    input  OUT_rqReady, OUT_memValid, OUT_memAddr, OUT_resValid, OUT_resRqID, OUT_resVpn,
           OUT_resPpn, OUT_resIsSuper, OUT_resRwx, OUT_resUser, OUT_resGlobl,
           OUT_resPageFault, OUT_busy
  );
endinterface

// File: rtl/page_walker.sv
// page_walker: Sv32 two-level page-table walker shared by the ifetch and load/store TLBs
module page_walker #(
  parameter int NUM_RQ = 2,
  parameter int ID_W = 1
) (
  input logic         clk,
  input logic         rst,
  page_walker_if.slave bus
);
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, gnt_id, idx;
  logic [19:0] vpn_q, vpn_d;
  logic [33:0] addr_q, addr_d;
  logic [21:0] ppn_q, ppn_d, pppn;
  logic [2:0] rwx_q, rwx_d;
  logic super_q, super_d, user_q, user_d, g_q, g_d, pf_q, pf_d;
  logic gnt_any, pv, pr, pw, px, pu, pg, pa, bad, leaf, done;
  assign pv = bus.IN_memRespData[0];
  assign pr = bus.IN_memRespData[1];
  assign pw = bus.IN_memRespData[2];
  assign px = bus.IN_memRespData[3];
  assign pu = bus.IN_memRespData[4];
  assign pg = bus.IN_memRespData[5];
  assign pa = bus.IN_memRespData[6];
  assign pppn = bus.IN_memRespData[31:10];
  assign bad = !pv || (!pr && pw);
  assign leaf = pr || px;
  // round-robin pick: scan from the requester after the last grant; the lowest offset wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int i = NUM_RQ; i >= 1; i--) begin
      idx = ID_W'((int'(rr_q) + i) % NUM_RQ);
      if (bus.IN_rqValid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  // walk sequencing and PTE decode
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    vpn_d = vpn_q;
    addr_d = addr_q;
    ppn_d = ppn_q;
    rwx_d = rwx_q;
    super_d = super_q;
    user_d = user_q;
    g_d = g_q;
    pf_d = pf_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        state_d = L1_REQ;
        rr_d = gnt_id;
        id_d = gnt_id;
        vpn_d = bus.IN_rqVpn[gnt_id];
        addr_d = {bus.IN_satpPpn, 12'b0} + {22'b0, bus.IN_rqVpn[gnt_id][19:10], 2'b0};
        ppn_d = '0;
        rwx_d = '0;
        super_d = 1'b0;
        user_d = 1'b0;
        g_d = 1'b0;
        pf_d = 1'b0;
      end
      L1_REQ, L0_REQ: if (addr_q[33:32] != 2'b0) begin
        state_d = DONE;
        ppn_d = 22'h100000;
      end else if (bus.IN_memReady) state_d = state_q == L1_REQ ? L1_WAIT : L0_WAIT;
      L1_WAIT, L0_WAIT: if (bus.IN_memRespValid) begin
        state_d = DONE;
        g_d = g_q | pg;
        if (bad) pf_d = 1'b1;
        else if (leaf) begin
          pf_d = !pa || (state_q == L1_WAIT && pppn[9:0] != 10'b0);
          ppn_d = pppn;
          rwx_d = {pr, pw, px};
          user_d = pu;
          super_d = state_q == L1_WAIT;
        end else if (state_q == L1_WAIT) begin
          state_d = L0_REQ;
          addr_d = {pppn, 12'b0} + {22'b0, vpn_q[9:0], 2'b0};
        end else pf_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and walk context registers; reset drops any walk in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      vpn_q <= '0;
      addr_q <= '0;
      ppn_q <= '0;
      rwx_q <= '0;
      super_q <= 1'b0;
      user_q <= 1'b0;
      g_q <= 1'b0;
      pf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      vpn_q <= vpn_d;
      addr_q <= addr_d;
      ppn_q <= ppn_d;
      rwx_q <= rwx_d;
      super_q <= super_d;
      user_q <= user_d;
      g_q <= g_d;
      pf_q <= pf_d;
    end
  end
  assign done = state_q == DONE;
  assign bus.OUT_rqReady = (gnt_any && state_q == IDLE && !rst) ? NUM_RQ'(1) << gnt_id : '0;
  assign bus.OUT_memValid = (state_q == L1_REQ || state_q == L0_REQ) && addr_q[33:32] == 2'b0;
  assign bus.OUT_memAddr = addr_q;
  assign bus.OUT_resValid = done;
  assign bus.OUT_resRqID = done ? id_q : '0;
  assign bus.OUT_resVpn = done ? vpn_q : '0;
  assign bus.OUT_resPpn = done && !pf_q ? ppn_q : '0;
  assign bus.OUT_resIsSuper = done && !pf_q && super_q;
  assign bus.OUT_resRwx = done && !pf_q ? rwx_q : '0;
  assign bus.OUT_resUser = done && !pf_q && user_q;
  assign bus.OUT_resGlobl = done && g_q;
  assign bus.OUT_resPageFault = done && pf_q;
  assign bus.OUT_busy = state_q != IDLE;
endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker: directed vector table plus arbitration, backpressure and reset sequences
module tb_page_walker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  page_walker_if #(.NUM_RQ(2), .ID_W(1)) bus ();
  page_walker #(.NUM_RQ(2), .ID_W(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [19:0] vpn;
    logic [21:0] satp;
    logic [31:0] l1;
    logic [31:0] l0;
    int          rq;
    logic        pf;
    logic [21:0] ppn;
    logic        sup;
    logic [2:0]  rwx;
    logic        usr;
    logic        glb;
    int          reads;
    logic [33:0] a0;
    logic [33:0] a1;
  } vec_t;
  vec_t v[10];

  int tests = 0;
  int fails = 0;
  int res_cnt = 0;
  int nrd = 0;
  logic [33:0] rd_addr[4];
  logic [31:0] mem_l1 = '0;
  logic [31:0] mem_l0 = '0;
  logic [33:0] hold_addr = '1;
  bit inj = 0;
  bit pend = 0;
  logic [31:0] pend_data = '0;
  logic r_id, r_sup, r_usr, r_glb, r_pf;
  logic [19:0] r_vpn;
  logic [21:0] r_ppn;
  logic [2:0] r_rwx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // memory: answers each accepted read on the following cycle, first read of a walk gets mem_l1
  initial begin
    bus.IN_memRespValid = 1'b0;
    bus.IN_memRespData = '0;
    forever begin
      @(negedge clk);
      bus.IN_memRespValid = pend | inj;
      bus.IN_memRespData = pend_data;
      pend = 0;
      if (bus.OUT_memValid && bus.IN_memReady) begin
        pend = bus.OUT_memAddr != hold_addr;
        pend_data = nrd == 0 ? mem_l1 : mem_l0;
        if (nrd < 4) rd_addr[nrd] = bus.OUT_memAddr;
        nrd++;
      end
    end
  end

  // result monitor
  initial forever begin
    @(negedge clk);
    if (bus.OUT_resValid) begin
      res_cnt++;
      r_id = bus.OUT_resRqID;
      r_vpn = bus.OUT_resVpn;
      r_ppn = bus.OUT_resPpn;
      r_sup = bus.OUT_resIsSuper;
      r_rwx = bus.OUT_resRwx;
      r_usr = bus.OUT_resUser;
      r_glb = bus.OUT_resGlobl;
      r_pf = bus.OUT_resPageFault;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic request(input int rq, input logic [19:0] vpn, input logic [21:0] satp);
    int n = 0;
    @(posedge clk); #1;
    bus.IN_rqVpn[rq] = vpn;
    bus.IN_satpPpn = satp;
    bus.IN_rqValid[rq] = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.OUT_rqReady[rq] && n < 20);
    chk("grant", bus.OUT_rqReady[rq], 1);
    @(posedge clk); #1;
    bus.IN_rqValid[rq] = 1'b0;
    bus.IN_satpPpn = 22'h3FFFFF;
  endtask

  task automatic wait_res(input int c0);
    int n = 0;
    while (res_cnt == c0 && n < 40) begin @(negedge clk); n++; end
    chk("result_timeout", res_cnt != c0, 1);
    repeat (3) @(negedge clk);
    chk("result_count", res_cnt - c0, 1);
  endtask

  task automatic run_vec(input int k);
    int c0 = res_cnt;
    mem_l1 = v[k].l1;
    mem_l0 = v[k].l0;
    nrd = 0;
    request(v[k].rq, v[k].vpn, v[k].satp);
    wait_res(c0);
    chk($sformatf("v%0d_pf", k), r_pf, v[k].pf);
    chk($sformatf("v%0d_ppn", k), r_ppn, v[k].ppn);
    chk($sformatf("v%0d_super", k), r_sup, v[k].sup);
    chk($sformatf("v%0d_rwx", k), r_rwx, v[k].rwx);
    chk($sformatf("v%0d_user", k), r_usr, v[k].usr);
    chk($sformatf("v%0d_globl", k), r_glb, v[k].glb);
    chk($sformatf("v%0d_id", k), r_id, v[k].rq);
    chk($sformatf("v%0d_vpn", k), r_vpn, v[k].vpn);
    chk($sformatf("v%0d_reads", k), nrd, v[k].reads);
    if (v[k].reads > 0) chk($sformatf("v%0d_addr0", k), rd_addr[0], v[k].a0);
    if (v[k].reads > 1) chk($sformatf("v%0d_addr1", k), rd_addr[1], v[k].a1);
  endtask

  initial begin
    int c0, n;
    logic [33:0] a;
    v[0] = '{20'h12345, 22'h80, 32'h00020401, 32'h00048C47, 0, 0, 22'h123, 0, 3'b110, 0, 0, 2, 34'h80120, 34'h81D14};
    v[1] = '{20'hABCDE, 22'h80, 32'h0010004B, 32'h0, 1, 0, 22'h400, 1, 3'b101, 0, 0, 1, 34'h80ABC, 34'h0};
    v[2] = '{20'h12345, 22'h80, 32'h0010044B, 32'h0, 0, 1, 22'h0, 0, 3'b000, 0, 0, 1, 34'h80120, 34'h0};
    v[3] = '{20'h12345, 22'h80, 32'h00000000, 32'h0, 1, 1, 22'h0, 0, 3'b000, 0, 0, 1, 34'h80120, 34'h0};
    v[4] = '{20'h12345, 22'h80, 32'h00020401, 32'h00000001, 0, 1, 22'h0, 0, 3'b000, 0, 0, 2, 34'h80120, 34'h81D14};
    v[5] = '{20'h12345, 22'h80, 32'h00000005, 32'h0, 1, 1, 22'h0, 0, 3'b000, 0, 0, 1, 34'h80120, 34'h0};
    v[6] = '{20'h12345, 22'h300000, 32'h0, 32'h0, 0, 0, 22'h100000, 0, 3'b000, 0, 0, 0, 34'h0, 34'h0};
    v[7] = '{20'h12345, 22'h80, 32'h00020401, 32'h00048C07, 1, 1, 22'h0, 0, 3'b000, 0, 0, 2, 34'h80120, 34'h81D14};
    v[8] = '{20'h003FF, 22'h80, 32'h00020421, 32'h00048C5B, 0, 0, 22'h123, 0, 3'b101, 1, 1, 2, 34'h80000, 34'h81FFC};
    v[9] = '{20'h12345, 22'h80, 32'hC0000001, 32'h0, 1, 0, 22'h100000, 0, 3'b000, 0, 0, 1, 34'h80120, 34'h0};
    bus.IN_rqValid = '0;
    bus.IN_rqVpn = '0;
    bus.IN_satpPpn = '0;
    bus.IN_memReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.OUT_busy, 0);
    chk("rst_resValid", bus.OUT_resValid, 0);
    chk("rst_memValid", bus.OUT_memValid, 0);
    chk("rst_memAddr", bus.OUT_memAddr, 0);
    chk("rst_rqReady", bus.OUT_rqReady, 0);
    chk("rst_resPpn", bus.OUT_resPpn, 0);

    // arbitration: previous grant is 0 after reset, so requester 1 wins, then requester 0
    mem_l1 = v[1].l1;
    nrd = 0;
    c0 = res_cnt;
    @(posedge clk); #1;
    bus.IN_rqVpn[0] = 20'h11111;
    bus.IN_rqVpn[1] = 20'h22222;
    bus.IN_satpPpn = 22'h80;
    bus.IN_rqValid = 2'b11;
    @(negedge clk);
    chk("arb_first", bus.OUT_rqReady, 2'b10);
    @(negedge clk);
    n = 0;
    while (bus.OUT_rqReady == 2'b00 && n < 30) begin @(negedge clk); nrd = 0; n++; end
    chk("arb_second", bus.OUT_rqReady, 2'b01);
    @(posedge clk); #1;
    bus.IN_rqValid = 2'b00;
    repeat (20) @(negedge clk);
    chk("arb_results", res_cnt - c0, 2);
    chk("arb_last_id", r_id, 0);
    chk("arb_last_vpn", r_vpn, 20'h11111);

    for (int k = 0; k < 10; k++) run_vec(k);

    // backpressure on the L1 read
    mem_l1 = v[0].l1;
    mem_l0 = v[0].l0;
    nrd = 0;
    c0 = res_cnt;
    bus.IN_memReady = 1'b0;
    request(0, 20'h12345, 22'h80);
    @(negedge clk);
    a = bus.OUT_memAddr;
    chk("bp_addr", a, 34'h80120);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.OUT_memValid, 1);
      chk("bp_stable", bus.OUT_memAddr, 34'h80120);
      chk("bp_busy", bus.OUT_busy, 1);
    end
    @(posedge clk); #1;
    bus.IN_memReady = 1'b1;
    wait_res(c0);
    chk("bp_ppn", r_ppn, 22'h123);
    chk("bp_reads", nrd, 2);

    // reset while waiting for the L0 response, then a stray response in IDLE
    mem_l1 = v[0].l1;
    mem_l0 = v[0].l0;
    hold_addr = 34'h81D14;
    nrd = 0;
    request(0, 20'h12345, 22'h80);
    n = 0;
    while (nrd < 2 && n < 30) begin @(negedge clk); n++; end
    chk("rw_l0_issued", nrd, 2);
    @(negedge clk);
    chk("rw_busy_before", bus.OUT_busy, 1);
    c0 = res_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_busy_after", bus.OUT_busy, 0);
    chk("rw_resValid", bus.OUT_resValid, 0);
    hold_addr = '1;
    inj = 1;
    @(negedge clk);
    @(posedge clk); #1;
    inj = 0;
    repeat (6) @(negedge clk);
    chk("rw_no_result", res_cnt - c0, 0);
    chk("rw_idle", bus.OUT_busy, 0);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
